// File: rtl/ctx_fifo_if.sv
// ---------------------------------------------------------------------------
// ctx_fifo_if -- handshake bundle for the multi-context FIFO store.
//
// Groups the push, pop, response, flush and status signals of ctx_fifo.
//   master : producer/consumer side (drives requests, observes status)
//   slave  : the FIFO itself
//
// Signals:
//   push_vld/push_ctx/push_data -> push_rdy    push channel
//   pop_vld/pop_ctx             -> pop_rdy     pop request channel
//   rsp_vld/rsp_ctx/rsp_data                   registered pop response
//   flush_vld/flush_ctx                        per-context discard
//   empty_o/full_o                             registered per-context status
//   occ_ctx -> occ_o                           occupancy query, present only
//                                              when CTX_FIFO_OCC_EN is defined
// ---------------------------------------------------------------------------
interface ctx_fifo_if #(
  parameter int CONTEXT_N = 128,
  parameter int ENTRIES_N = 4,
  parameter int W         = 32
);
  localparam int CW = (CONTEXT_N > 1) ? $clog2(CONTEXT_N) : 1;

  logic                 push_vld;
  logic [CW-1:0]        push_ctx;
  logic [W-1:0]         push_data;
  logic                 push_rdy;

  logic                 pop_vld;
  logic [CW-1:0]        pop_ctx;
  logic                 pop_rdy;

  logic                 rsp_vld;
  logic [CW-1:0]        rsp_ctx;
  logic [W-1:0]         rsp_data;

  logic                 flush_vld;
  logic [CW-1:0]        flush_ctx;

  logic [CONTEXT_N-1:0] empty_o;
  logic [CONTEXT_N-1:0] full_o;

`ifdef CTX_FIFO_OCC_EN
  localparam int OW = $clog2(ENTRIES_N + 1);
  logic [CW-1:0]        occ_ctx;
  logic [OW-1:0]        occ_o;
`endif

  modport master (
    output push_vld, push_ctx, push_data, pop_vld, pop_ctx, flush_vld, flush_ctx,
    input  push_rdy, pop_rdy, rsp_vld, rsp_ctx, rsp_data, empty_o, full_o
`ifdef CTX_FIFO_OCC_EN
    , output occ_ctx, input occ_o
`endif
  );

  modport slave (
    input  push_vld, push_ctx, push_data, pop_vld, pop_ctx, flush_vld, flush_ctx,
    output push_rdy, pop_rdy, rsp_vld, rsp_ctx, rsp_data, empty_o, full_o
`ifdef CTX_FIFO_OCC_EN
    , input occ_ctx, output occ_o
`endif
  );

endinterface

// File: rtl/ctx_fifo.sv
// ---------------------------------------------------------------------------
// ctx_fifo -- CONTEXT_N independent FIFOs, ENTRIES_N deep, W bits wide,
// sharing one storage array (context c owns rows c*ENTRIES_N .. +ENTRIES_N-1).
//
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rst  : asynchronous, active-low reset
//   bus  : ctx_fifo_if.slave (push / pop / response / flush / status)
//
// Optional: define CTX_FIFO_OCC_EN to add the occupancy query
// (bus.occ_ctx -> bus.occ_o, one cycle latency).
//
// Pop responses come from a registered read of the storage array, so data
// pushed in one cycle is poppable from the next. A push and pop on the same
// context can never touch the same row in one cycle: that would need an
// empty context (pop blocked) or a full one (push blocked).
// ---------------------------------------------------------------------------
module ctx_fifo #(
  parameter int CONTEXT_N = 128,
  parameter int ENTRIES_N = 4,
  parameter int W         = 32
) (
  input  logic       clk,
  input  logic       rst,
  ctx_fifo_if.slave  bus
);

  localparam int CW    = (CONTEXT_N > 1) ? $clog2(CONTEXT_N) : 1;
  localparam int PW    = $clog2(ENTRIES_N);
  localparam int OW    = $clog2(ENTRIES_N + 1);
  localparam int DEPTH = CONTEXT_N * ENTRIES_N;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Shared storage, deliberately not reset.
  logic [W-1:0] mem_q [DEPTH];

  // Per-context pointers flattened so the selected context can be muxed out.
  logic [CONTEXT_N*PW-1:0] rd_ptr_flat;
  logic [CONTEXT_N*PW-1:0] wr_ptr_flat;
  logic [CONTEXT_N-1:0]    empty_vec;
  logic [CONTEXT_N-1:0]    full_vec;

  logic          push_rdy;
  logic          pop_rdy;
  logic          push_acc;
  logic          pop_acc;
  logic [PW-1:0] push_wr_ptr;
  logic [PW-1:0] pop_rd_ptr;
  logic [AW-1:0] push_addr;
  logic [AW-1:0] pop_addr;

  logic          rsp_vld_q;
  logic [CW-1:0] rsp_ctx_q;
  logic [W-1:0]  rsp_data_q;

  // Ready depends only on registered status and the current requests; a
  // same-context flush wins over push and pop.
  assign push_rdy = !full_vec[bus.push_ctx] &&
                    !(bus.flush_vld && (bus.flush_ctx == bus.push_ctx));
  assign pop_rdy  = !empty_vec[bus.pop_ctx] &&
                    !(bus.flush_vld && (bus.flush_ctx == bus.pop_ctx));
  assign push_acc = bus.push_vld && push_rdy;
  assign pop_acc  = bus.pop_vld  && pop_rdy;

  assign push_wr_ptr = wr_ptr_flat[int'(bus.push_ctx)*PW +: PW];
  assign pop_rd_ptr  = rd_ptr_flat[int'(bus.pop_ctx)*PW +: PW];
  assign push_addr   = AW'(int'(bus.push_ctx) * ENTRIES_N + int'(push_wr_ptr));
  assign pop_addr    = AW'(int'(bus.pop_ctx)  * ENTRIES_N + int'(pop_rd_ptr));

`ifdef CTX_FIFO_OCC_EN
  logic [CONTEXT_N*OW-1:0] cnt_flat;
  logic [OW-1:0]           occ_q;
`endif

  // -------------------------------------------------------------------------
  // Per-context state: pointers, count and registered status bits.
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < CONTEXT_N; gi++) begin : g_ctx
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [OW-1:0] cnt_q, cnt_d;
    logic          empty_q, full_q;
    logic          push_hit, pop_hit, flush_hit;

    assign push_hit  = push_acc      && (bus.push_ctx  == CW'(gi));
    assign pop_hit   = pop_acc       && (bus.pop_ctx   == CW'(gi));
    assign flush_hit = bus.flush_vld && (bus.flush_ctx == CW'(gi));

    always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      if (flush_hit) begin
        rd_ptr_d = '0;
        wr_ptr_d = '0;
        cnt_d    = '0;
      end else begin
        // Explicit wrap so ENTRIES_N need not be a power of two.
        if (push_hit)
          wr_ptr_d = (wr_ptr_q == PW'(ENTRIES_N - 1)) ? '0 : wr_ptr_q + PW'(1);
        if (pop_hit)
          rd_ptr_d = (rd_ptr_q == PW'(ENTRIES_N - 1)) ? '0 : rd_ptr_q + PW'(1);
        cnt_d = cnt_q + OW'(push_hit) - OW'(pop_hit);
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        cnt_q    <= '0;
        empty_q  <= 1'b1;
        full_q   <= 1'b0;
      end else begin
        rd_ptr_q <= rd_ptr_d;
        wr_ptr_q <= wr_ptr_d;
        cnt_q    <= cnt_d;
        // Status tracks the count being written this edge.
        empty_q  <= (cnt_d == '0);
        full_q   <= (cnt_d == OW'(ENTRIES_N));
      end
    end

    assign rd_ptr_flat[gi*PW +: PW] = rd_ptr_q;
    assign wr_ptr_flat[gi*PW +: PW] = wr_ptr_q;
    assign empty_vec[gi]            = empty_q;
    assign full_vec[gi]             = full_q;
`ifdef CTX_FIFO_OCC_EN
    assign cnt_flat[gi*OW +: OW]    = cnt_q;
`endif
  end

  // -------------------------------------------------------------------------
  // Storage write port.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push_acc)
      mem_q[push_addr] <= bus.push_data;
  end

  // -------------------------------------------------------------------------
  // Registered read / response. rsp_ctx and rsp_data hold between pops.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_vld_q  <= 1'b0;
      rsp_ctx_q  <= '0;
      rsp_data_q <= '0;
    end else begin
      rsp_vld_q <= pop_acc;
      if (pop_acc) begin
        rsp_ctx_q  <= bus.pop_ctx;
        rsp_data_q <= mem_q[pop_addr];
      end
    end
  end

`ifdef CTX_FIFO_OCC_EN
  // Samples the count before the edge, so occ_o shows the count after the
  // previous edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      occ_q <= '0;
    else
      occ_q <= cnt_flat[int'(bus.occ_ctx)*OW +: OW];
  end
  assign bus.occ_o = occ_q;
`endif

  assign bus.push_rdy = push_rdy;
  assign bus.pop_rdy  = pop_rdy;
  assign bus.rsp_vld  = rsp_vld_q;
  assign bus.rsp_ctx  = rsp_ctx_q;
  assign bus.rsp_data = rsp_data_q;
  assign bus.empty_o  = empty_vec;
  assign bus.full_o   = full_vec;

endmodule

// File: doc/ctx_fifo.md
Name: ctx_fifo

Overview:
- Multi-context FIFO store: CONTEXT_N independent queues, each ENTRIES_N deep, W bits wide, in one shared storage array.
- Parametrised successor of the fixed-width context store used under the top-level testbench. Adds:
  - configurable data width
  - per-context valid/ready push/pop
  - per-context flush
  - registered full/empty status vectors
- Sits between the context producer and its consumer in the v datapath.

Parameters:
- CONTEXT_N, 128, number of independent contexts (≥1)
- ENTRIES_N, 4, entries per context (≥2; need not be a power of two)
- W, 32, data width in bits
- Derived: CW = $clog2(CONTEXT_N) (min 1), PW = $clog2(ENTRIES_N), OW = $clog2(ENTRIES_N+1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous assert, active-low (rst==0 resets)
- push_vld  in  1  push request
- push_ctx  in  CW  target context of push
- push_data  in  W  push payload
- push_rdy  out  1  push accepted when push_vld & push_rdy
- pop_vld  in  1  pop request
- pop_ctx  in  CW  source context of pop
- pop_rdy  out  1  pop accepted when pop_vld & pop_rdy
- rsp_vld  out  1  pop response valid (registered)
- rsp_ctx  out  CW  context of response
- rsp_data  out  W  popped head entry
- flush_vld  in  1  discard all entries of flush_ctx
- flush_ctx  in  CW  context to flush
- empty_o  out  CONTEXT_N  per-context empty (registered)
- full_o  out  CONTEXT_N  per-context full (registered)

Behaviour:
- Reset (rst==0, async):
  - all rd/wr pointers = 0; all counts = 0
  - empty_o = all 1s; full_o = all 0s
  - rsp_vld = 0; rsp_ctx = 0; rsp_data = 0
  - storage array is not reset
- Per context state: rd_ptr[PW], wr_ptr[PW], cnt[OW].
  - Pointers wrap ENTRIES_N-1 → 0, explicit compare, no modulo-2 assumption.
- push_rdy = !full_o[push_ctx] & !(flush_vld & flush_ctx==push_ctx). Combinational from registered state and inputs.
- pop_rdy = !empty_o[pop_ctx] & !(flush_vld & flush_ctx==pop_ctx). No empty-bypass: pushed data is poppable from the next cycle onward.
- Push accept: mem[push_ctx][wr_ptr] <= push_data; wr_ptr++; cnt++.
- Pop accept: rd_ptr++; cnt--. Next cycle: rsp_vld=1, rsp_ctx=pop_ctx, rsp_data = entry at old rd_ptr. Latency exactly 1; no backpressure on rsp.
- rsp_vld=0 in any cycle following a non-accepted pop. rsp_ctx and rsp_data hold their last values.
- Push and pop on the same context in the same cycle (both accepted): cnt unchanged; both pointers advance.
  - Full context: push_rdy=0 even if a pop is accepted that cycle. No full-bypass.
- Push and pop on different contexts in the same cycle: fully independent.
- Flush: rd_ptr=wr_ptr=0, cnt=0 next cycle. Same-context push/pop are blocked via rdy that cycle. Other contexts are unaffected.
- A flush never cancels a response already registered from the previous cycle.
- empty_o[c] = (cnt_next==0), full_o[c] = (cnt_next==ENTRIES_N), both registered. They reflect state after the current edge.
- Reset mid-operation: a pending rsp_vld is dropped immediately (async). All contexts become empty.

Optional Feature:
- Macro CTX_FIFO_OCC_EN.
- Defined: adds ports occ_ctx (in, CW) and occ_o (out, OW).
  - occ_o = cnt[occ_ctx] registered, 1-cycle latency, reflecting the count after the previous edge.
  - Reset value 0.
- Undefined: ports absent, no occupancy mux logic.
- Core behaviour is identical either way.

Test Plan:
- Reset then idle → empty_o=all 1s, full_o=0, push_rdy=1, pop_rdy=0, rsp_vld=0.
- Push 0xA0..0xA3 into ctx 5 (ENTRIES_N=4) → full_o[5]=1 after 4th edge; 5th push sees push_rdy=0. Pops return 0xA0,0xA1,0xA2,0xA3 in order, each 1 cycle after accept, rsp_ctx=5.
- Wrap-around: 6 push/pop pairs on ctx 0 with ENTRIES_N=3 → FIFO order preserved across the pointer wrap; empty_o[0]=1 at end.
- Simultaneous push 0x11 to ctx 2 and pop from ctx 2 holding 1 entry (0x10) → rsp_data=0x10; cnt stays 1; next pop returns 0x11.
- Flush ctx 7 (3 entries) in the same cycle as push_vld to ctx 7 and pop_vld to ctx 9 → push_rdy=0; ctx 9 pop proceeds; empty_o[7]=1 next cycle.
- Async rst low mid-stream with rsp_vld=1 → rsp_vld=0 immediately; after release all contexts empty. With CTX_FIFO_OCC_EN: occ_o=0.
